game_flow_controller: RTL and testbench
=======================================

GAME_FLOW_CONTROLLER -- requirements
Module: game_flow_controller

Interface
REQ-001 SHALL have parameter START_LIVES, default 3, meaning lives loaded at game start (legal range 1..3).
REQ-002 SHALL have parameter INVULN_CYCLES, default 25000000, meaning clock cycles of post-hit invulnerability (>=1; 1 s at 25 MHz).
REQ-003 SHALL have port i_Clk  input  1  system clock; all state changes on its rising edge.
REQ-004 SHALL have port i_Rst_L  input  1  reset; one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port i_Start  input  1  debounced start/restart button, level.
REQ-006 SHALL have port i_Collided  input  1  collision indication from game logic, level, synchronous to i_Clk.
REQ-007 SHALL have port o_Lives  output  2  remaining lives, binary.
REQ-008 SHALL have port o_Lives_LED  output  3  thermometer lives display: bit0 lit for lives>=1, bit1 for >=2, bit2 for >=3.
REQ-009 SHALL have port o_Game_Active  output  1  high in PLAY and HIT.
REQ-010 SHALL have port o_Freeze  output  1  high in HIT; game logic stops movement.
REQ-011 SHALL have port o_Lost_Life  output  1  one-cycle pulse per accepted collision.
REQ-012 SHALL have port o_Game_Over  output  1  high in OVER.

Function
REQ-013 SHALL implement a four-state FSM: IDLE, PLAY, HIT, OVER; all outputs registered.
REQ-014 SHALL detect start_edge = i_Start AND NOT(previous i_Start); previous-start register resets to 1, so a button held through reset does not start a game.
REQ-015 SHALL detect coll_edge = i_Collided AND NOT(previous i_Collided); previous-collision register resets to 0 and updates every cycle in every state.
REQ-016 IDLE: on start_edge -> PLAY, lives <= START_LIVES; all other inputs ignored.
REQ-017 PLAY: on coll_edge, lives <= lives-1 and o_Lost_Life = 1 for exactly the following cycle.
REQ-018 PLAY: if coll_edge occurs with lives == 1 -> OVER with lives = 0; otherwise -> HIT with timer loaded with INVULN_CYCLES-1.
REQ-019 HIT: timer decrements by 1 per cycle; collisions ignored (no decrement, no pulse); at timer == 0 -> PLAY on next edge; HIT lasts exactly INVULN_CYCLES cycles.
REQ-020 A collision level still high on return to PLAY SHALL NOT cost a life; only a new rising edge counts.
REQ-021 OVER: on start_edge -> PLAY, lives <= START_LIVES, o_Game_Over falls the same cycle o_Game_Active rises.
REQ-022 start_edge in PLAY or HIT SHALL be ignored.
REQ-023 Simultaneous start_edge and coll_edge in IDLE or OVER: start wins, collision ignored, lives = START_LIVES.
REQ-024 Lives SHALL never underflow below 0 nor exceed START_LIVES; no decrement in IDLE or OVER.
REQ-025 Timer width SHALL be ceil(log2(INVULN_CYCLES))+1 bits minimum; no wrap permitted.
REQ-026 Output latency: o_Lives, o_Lives_LED and state outputs update one cycle after the triggering edge-qualified input sample.

Reset
REQ-027 While i_Rst_L = 0: state IDLE, lives = START_LIVES, o_Lives = START_LIVES, o_Lives_LED = thermometer(START_LIVES) (3'b111 at default), timer = 0, o_Game_Active = o_Freeze = o_Lost_Life = o_Game_Over = 0.
REQ-028 Reset asserted mid-game (PLAY, HIT or OVER) SHALL immediately force the REQ-027 values, without waiting for a clock edge.
REQ-029 After deassertion, the first state change requires a fresh start_edge.

Verification
REQ-030 Reset release with i_Start held high, then held 10 cycles -> remains IDLE; release then press -> PLAY, o_Lives = 3, o_Lives_LED = 3'b111.
REQ-031 INVULN_CYCLES = 4; in PLAY, pulse i_Collided one cycle -> o_Lost_Life one cycle, o_Lives = 2, LED 3'b011, o_Freeze high exactly 4 cycles, then PLAY.
REQ-032 INVULN_CYCLES = 4; hold i_Collided high through HIT and 3 cycles beyond -> only one life lost, o_Lives = 2.
REQ-033 Three separated collisions from PLAY -> o_Lives 2, 1, 0; after the third, state OVER, o_Game_Over = 1, LED 3'b000, o_Freeze = 0.
REQ-034 In OVER, assert i_Start and i_Collided rising the same cycle -> PLAY, o_Lives = 3, no o_Lost_Life pulse.
REQ-035 Assert i_Rst_L = 0 mid-HIT between clock edges -> outputs take REQ-027 values before the next rising edge.

Source files
------------

// File: rtl/game_flow_controller.sv
// Game flow sequencer: start/restart, life accounting, post-hit invulnerability window.
// Every output is registered and derived from the next-state values.
module game_flow_controller #(
  parameter int unsigned START_LIVES   = 3,
  parameter int unsigned INVULN_CYCLES = 25000000
) (
  input  logic       i_Clk,
  input  logic       i_Rst_L,
  input  logic       i_Start,
  input  logic       i_Collided,
  output logic [1:0] o_Lives,
  output logic [2:0] o_Lives_LED,
  output logic       o_Game_Active,
  output logic       o_Freeze,
  output logic       o_Lost_Life,
  output logic       o_Game_Over
);

  localparam int unsigned TIMER_W = $clog2(INVULN_CYCLES) + 1;
  localparam logic [1:0] LIVES_INIT = 2'(START_LIVES);
  localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(INVULN_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PLAY = 2'd1,
    HIT  = 2'd2,
    OVER = 2'd3
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           lives_q, lives_d;
  logic [TIMER_W-1:0]   timer_q, timer_d;
  logic                 start_prev_q;
  logic                 coll_prev_q;
  logic                 lost_d;
  logic                 start_edge;
  logic                 coll_edge;

  function automatic logic [2:0] therm(input logic [1:0] n);
    return {n == 2'd3, n >= 2'd2, n != 2'd0};
  endfunction

  // Next-state and life/timer update
  always_comb begin
    state_d    = state_q;
    lives_d    = lives_q;
    timer_d    = timer_q;
    lost_d     = 1'b0;
    start_edge = i_Start & ~start_prev_q;
    coll_edge  = i_Collided & ~coll_prev_q;

    case (state_q)
      IDLE, OVER: begin
        if (start_edge) begin
          state_d = PLAY;
          lives_d = LIVES_INIT;
        end
      end
      PLAY: begin
        if (coll_edge && (lives_q != 2'd0)) begin
          lives_d = lives_q - 2'd1;
          lost_d  = 1'b1;
          if (lives_q == 2'd1) begin
            state_d = OVER;
          end else begin
            state_d = HIT;
            timer_d = TIMER_LOAD;
          end
        end
      end
      HIT: begin
        if (timer_q == '0) begin
          state_d = PLAY;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Start edge register resets high so a button held through reset cannot start a game
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q       <= IDLE;
      lives_q       <= LIVES_INIT;
      timer_q       <= '0;
      start_prev_q  <= 1'b1;
      coll_prev_q   <= 1'b0;
      o_Lives       <= LIVES_INIT;
      o_Lives_LED   <= therm(LIVES_INIT);
      o_Game_Active <= 1'b0;
      o_Freeze      <= 1'b0;
      o_Lost_Life   <= 1'b0;
      o_Game_Over   <= 1'b0;
    end else begin
      state_q       <= state_d;
      lives_q       <= lives_d;
      timer_q       <= timer_d;
      start_prev_q  <= i_Start;
      coll_prev_q   <= i_Collided;
      o_Lives       <= lives_d;
      o_Lives_LED   <= therm(lives_d);
      o_Game_Active <= (state_d == PLAY) || (state_d == HIT);
      o_Freeze      <= (state_d == HIT);
      o_Lost_Life   <= lost_d;
      o_Game_Over   <= (state_d == OVER);
    end
  end

endmodule

// File: tb/tb_game_flow_controller.sv
// Directed bench for game_flow_controller with a short invulnerability window.
module tb_game_flow_controller;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       coll;
  logic [1:0] lives;
  logic [2:0] led;
  logic       active;
  logic       freeze;
  logic       lost;
  logic       over;

  int checks = 0;
  int errors = 0;

  game_flow_controller #(
    .START_LIVES   (3),
    .INVULN_CYCLES (4)
  ) dut (
    .i_Clk         (clk),
    .i_Rst_L       (rst_n),
    .i_Start       (start),
    .i_Collided    (coll),
    .o_Lives       (lives),
    .o_Lives_LED   (led),
    .o_Game_Active (active),
    .o_Freeze      (freeze),
    .o_Lost_Life   (lost),
    .o_Game_Over   (over)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {lives[1:0], led[2:0], active, freeze, lost, over}
  typedef struct {
    logic       start;
    logic       coll;
    logic [8:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic s, input logic c, input logic [1:0] l,
                     input logic [2:0] d, input logic a, input logic f,
                     input logic p, input logic o);
    vec_t v;
    v.start = s;
    v.coll  = c;
    v.exp   = {l, d, a, f, p, o};
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [8:0] exp);
    logic [8:0] act;
    act = {lives, led, active, freeze, lost, over};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%b required=%b (lives,led,act,frz,lost,over)", name, act, exp);
    end
  endtask

  localparam logic [8:0] RESET_OUT = {2'd3, 3'b111, 4'b0000};

  initial begin
    // held through reset and 10 more cycles: must stay IDLE
    for (int i = 0; i < 10; i++) add(1, 0, 2'd3, 3'b111, 0, 0, 0, 0);
    add(0, 0, 2'd3, 3'b111, 0, 0, 0, 0);
    add(1, 0, 2'd3, 3'b111, 1, 0, 0, 0);   // fresh press -> PLAY
    add(1, 0, 2'd3, 3'b111, 1, 0, 0, 0);
    add(0, 1, 2'd2, 3'b011, 1, 1, 1, 0);   // hit 1
    add(0, 0, 2'd2, 3'b011, 1, 1, 0, 0);
    add(0, 0, 2'd2, 3'b011, 1, 1, 0, 0);
    add(0, 0, 2'd2, 3'b011, 1, 1, 0, 0);
    add(0, 0, 2'd2, 3'b011, 1, 0, 0, 0);   // freeze lasted exactly 4 cycles
    add(0, 1, 2'd1, 3'b001, 1, 1, 1, 0);   // hit 2, collision then held
    for (int i = 0; i < 3; i++) add(0, 1, 2'd1, 3'b001, 1, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 1, 2'd1, 3'b001, 1, 0, 0, 0);
    add(1, 1, 2'd1, 3'b001, 1, 0, 0, 0);   // start in PLAY ignored
    add(0, 0, 2'd1, 3'b001, 1, 0, 0, 0);
    add(0, 1, 2'd0, 3'b000, 0, 0, 1, 1);   // hit 3 -> OVER
    add(0, 0, 2'd0, 3'b000, 0, 0, 0, 1);
    add(0, 1, 2'd0, 3'b000, 0, 0, 0, 1);   // no decrement in OVER
    add(0, 0, 2'd0, 3'b000, 0, 0, 0, 1);
    add(1, 1, 2'd3, 3'b111, 1, 0, 0, 0);   // start beats collision
    add(0, 0, 2'd3, 3'b111, 1, 0, 0, 0);

    rst_n = 1'b0;
    start = 1'b1;
    coll  = 1'b0;
    repeat (2) @(negedge clk);
    check("reset", RESET_OUT);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      start = vecs[i].start;
      coll  = vecs[i].coll;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset in the middle of HIT
    @(negedge clk);
    start = 1'b0;
    coll  = 1'b1;
    @(posedge clk);
    #1;
    check("enter_hit", {2'd2, 3'b011, 4'b1110});
    @(negedge clk);
    coll = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_mid_hit", RESET_OUT);
    @(negedge clk);
    rst_n = 1'b1;

    // Collision in IDLE after reset does nothing; a fresh start edge is required
    coll = 1'b1;
    @(posedge clk);
    #1;
    check("idle_ignores_coll", RESET_OUT);
    @(negedge clk);
    coll  = 1'b0;
    start = 1'b1;
    @(posedge clk);
    #1;
    check("restart_after_reset", {2'd3, 3'b111, 4'b1000});
    @(negedge clk);
    start = 1'b0;
    coll  = 1'b1;
    @(posedge clk);
    #1;
    check("hit_after_restart", {2'd2, 3'b011, 4'b1110});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
